mem_responder: RTL and testbench

- Memory-side responder for the controller's request/response bus: accepts one request at a time, applies a fixed access latency, then returns a write acknowledge or a burst of read data.
- Owns a DEPTH = 2^ADDR_W word storage array.
- Sits opposite the controller as the far end of the same bus; the controller issues, this block answers.

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_lat_counter.sv | 40 ++++
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory request/response bus (mem_defs).
// Holds the state encodings and default width/latency constants used by
// both the controller and this responder, plus the parity helper.
// Optional feature macro used by the responder: RESP_PARITY_EN.
package mem_responder_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LATENCY = 4;
    localparam int DEF_LEN_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Even parity over a word zero-extended to 32 bits.
    function automatic logic calc_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mem_responder_lat_counter.sv
// Loadable down-counter used to time the access latency of a request.
// done_o is high whenever the counter holds zero.
module lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, otherwise decrement while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits a fixed
// latency, then returns a write acknowledge or a burst of read beats.
// Optional RESP_PARITY_EN adds resp_parity (even parity of resp_data).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_write
`ifdef RESP_PARITY_EN
    ,
    output logic              resp_parity
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              wr_q, wr_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              rwrite_q, rwrite_d;

    logic              mem_we_s;
    logic              lat_load_s;
    logic              lat_en_s;
    logic              lat_done_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [LEN_W-1:0]  next_beat_s;

    assign next_addr_s = addr_q + ADDR_W'(1);
    assign next_beat_s = beat_q + LEN_W'(1);

    lat_counter #(
        .W(CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lat_load_s),
        .load_val_i (LAT_LOAD),
        .en_i       (lat_en_s),
        .done_o     (lat_done_s)
    );

    // Next-state and response-beat selection for the request/response FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wr_d       = wr_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        rwrite_d   = rwrite_q;
        mem_we_s   = 1'b0;
        lat_load_s = 1'b0;
        lat_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    wr_d     = req_write;
                    addr_d   = req_addr;
                    len_d    = req_len;
                    beat_d   = {LEN_W{1'b0}};
                    mem_we_s = req_write;
                    ready_d  = 1'b0;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_WAIT;
                        lat_load_s = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_done_s) begin
                    state_d = ST_RESP;
                end else begin
                    lat_en_s = 1'b1;
                end
            end
            ST_RESP: begin
                if (!valid_q) begin
                    // First beat: present the registered response one cycle after entry.
                    valid_d  = 1'b1;
                    data_d   = wr_q ? {DATA_W{1'b0}} : mem_q[addr_q];
                    last_d   = wr_q | (beat_q == len_q);
                    rwrite_d = wr_q;
                end else if (resp_ready) begin
                    if (last_q) begin
                        state_d  = ST_IDLE;
                        ready_d  = 1'b1;
                        valid_d  = 1'b0;
                        data_d   = {DATA_W{1'b0}};
                        last_d   = 1'b0;
                        rwrite_d = 1'b0;
                    end else begin
                        // Following beat loads on the handshake edge: no bubble.
                        addr_d = next_addr_s;
                        beat_d = next_beat_s;
                        data_d = mem_q[next_addr_s];
                        last_d = (next_beat_s == len_q);
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                valid_d  = 1'b0;
                data_d   = {DATA_W{1'b0}};
                last_d   = 1'b0;
                rwrite_d = 1'b0;
            end
        endcase
    end

    // Control, address and response registers; array contents are not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= {ADDR_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            beat_q   <= {LEN_W{1'b0}};
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= {DATA_W{1'b0}};
            last_q   <= 1'b0;
            rwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wr_q     <= wr_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            rwrite_q <= rwrite_d;
        end
    end

    // Storage array write port: a write commits on its accept edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

`ifdef RESP_PARITY_EN
    logic parity_q;

    // Parity registered alongside the data so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= calc_parity(32'(data_d));
        end
    end

    assign resp_parity = parity_q;
`endif

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_last  = last_q;
    assign resp_write = rwrite_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver pushes expected beats from
// a plain array model at accept time; a monitor pops and compares them.
module tb_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       wr;
        int         exp_cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [1:0] req_len;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_last;
    logic       resp_write;
`ifdef RESP_PARITY_EN
    logic       resp_parity;
`endif

    mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_write (resp_write)
`ifdef RESP_PARITY_EN
        ,
        .resp_parity(resp_parity)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rr_mode = 0;
    int         beats_seen = 0;
    int         stall_cnt = 0;
    logic [7:0] model_mem [32];
    exp_t       sb [$];
    logic       prev_valid = 1'b0;
    logic       last_hs = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // resp_ready driver: always-ready, random, or a 3-cycle stall on beat 2.
    always @(posedge clk) begin
        #1;
        if (rr_mode == 0) begin
            resp_ready = 1'b1;
        end else if (rr_mode == 1) begin
            resp_ready = 1'($urandom_range(0, 1));
        end else begin
            if (resp_valid && beats_seen == 1 && stall_cnt < 3) begin
                resp_ready = 1'b0;
                stall_cnt++;
            end else begin
                resp_ready = 1'b1;
            end
        end
    end

    // Monitor: compares every presented beat against the scoreboard front.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_valid", resp_valid, 1'b0);
            chk("rst_ready", req_ready, 1'b0);
            prev_valid = 1'b0;
            last_hs = 1'b0;
        end else begin
            if (last_hs) begin
                chk("ready_after_last", req_ready, 1'b1);
                last_hs = 1'b0;
            end
            if (req_ready && resp_valid) begin
                chk("ready_and_valid", 32'd1, 32'd0);
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", resp_valid, 1'b0);
                end else begin
                    e = sb[0];
                    if (!prev_valid) chk("latency_cycle", cyc, e.exp_cyc);
                    chk("resp_data", resp_data, e.data);
                    chk("resp_last", resp_last, e.last);
                    chk("resp_write", resp_write, e.wr);
`ifdef RESP_PARITY_EN
                    chk("resp_parity", resp_parity, ^e.data);
`endif
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        beats_seen++;
                        if (resp_last) last_hs = 1'b1;
                    end
                end
            end
            prev_valid = resp_valid;
        end
    end

    // Issue one request once the responder is ready and record its expected response.
    task automatic do_req(input logic wr, input logic [4:0] a, input logic [1:0] l, input logic [7:0] wd);
        int   w;
        int   acc;
        exp_t e;
        logic [4:0] idx;
        @(posedge clk); #1;
        w = 0;
        while (!req_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1'b1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
        req_wdata = wd;
        acc = cyc + 1;
        if (wr) begin
            model_mem[a] = wd;
            e.data = 8'h00; e.last = 1'b1; e.wr = 1'b1; e.exp_cyc = acc + LAT;
            sb.push_back(e);
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                idx = a + 5'(i);
                e.data = model_mem[idx];
                e.last = (i == int'(l));
                e.wr = 1'b0;
                e.exp_cyc = (i == 0) ? acc + LAT : -1;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 5'($urandom);
        req_len   = 2'($urandom);
        req_wdata = 8'($urandom);
    endtask

    // Wait until every expected beat has been seen and the responder is idle.
    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_len = 2'd0; req_wdata = 8'd0;
        resp_ready = 1'b1;
        #2;
        chk("reset_valid", resp_valid, 1'b0);
        chk("reset_ready", req_ready, 1'b0);
        chk("reset_data", resp_data, 8'h00);
        chk("reset_last", resp_last, 1'b0);
        chk("reset_write", resp_write, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", req_ready, 1'b1);
        chk("post_reset_valid", resp_valid, 1'b0);

        // Fill the whole array so later reads are defined.
        for (int a = 0; a < 32; a++) do_req(1'b1, 5'(a), 2'd0, 8'($urandom));
        drain();

        // Write then read back a single word.
        do_req(1'b1, 5'd3, 2'd0, 8'hA5);
        drain();
        do_req(1'b0, 5'd3, 2'd0, 8'h00);
        drain();

        // Wrapping burst 30,31,0,1 with continuous ready.
        do_req(1'b1, 5'd30, 2'd0, 8'd1);
        do_req(1'b1, 5'd31, 2'd0, 8'd2);
        do_req(1'b1, 5'd0,  2'd0, 8'd3);
        do_req(1'b1, 5'd1,  2'd0, 8'd4);
        drain();
        do_req(1'b0, 5'd30, 2'd3, 8'h00);
        drain();

        // Same burst with a three-cycle stall on the second beat.
        beats_seen = 0; stall_cnt = 0; rr_mode = 2;
        do_req(1'b0, 5'd30, 2'd3, 8'h00);
        drain();
        chk("stall_cycles", stall_cnt, 3);
        rr_mode = 0;

        // Reset pulse while a read is waiting out its latency.
        do_req(1'b0, 5'd3, 2'd0, 8'h00);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", resp_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        chk("midrst_data", resp_data, 8'h00);
        chk("midrst_last", resp_last, 1'b0);
        chk("midrst_write", resp_write, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        do_req(1'b0, 5'd3, 2'd0, 8'h00);
        drain();

        // Parity-relevant words (checked by the monitor when enabled).
        do_req(1'b1, 5'd10, 2'd0, 8'h07);
        do_req(1'b1, 5'd11, 2'd0, 8'h03);
        do_req(1'b0, 5'd10, 2'd0, 8'h00);
        do_req(1'b0, 5'd11, 2'd0, 8'h00);
        drain();

        // Random traffic with random backpressure.
        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom_range(0, 2) == 0), 5'($urandom), 2'($urandom), 8'($urandom));
        end
        drain();
        rr_mode = 0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
